// File: rtl/snake_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snake_game_ctrl
// Brief    : Game-flow FSM for the snake engine: start/step strobes, speed
//            ramp with length, single-entry turn queue and high-score tracking.
// Revision : 1.0 - initial release
// ============================================================================
module snake_game_ctrl #(
    parameter int CNT_W       = 24,
    parameter int BASE_PERIOD = 25,
    parameter int MIN_PERIOD  = 8,
    parameter int SPEED_STEP  = 1,
    parameter int COUNT_STEPS = 3
) (
    input  logic       CLOCK,
    input  logic       reset,
    input  logic       center_pulse,
    input  logic       left_pulse,
    input  logic       right_pulse,
    input  logic       die,
    input  logic [4:0] length,
    output logic       start,
    output logic       step_en,
    output logic       turn_left,
    output logic       turn_right,
    output logic [2:0] state,
    output logic [1:0] countdown,
    output logic [4:0] score,
    output logic [4:0] high_score
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT      = 3'd1,
        S_COUNTDOWN = 3'd2,
        S_PLAY      = 3'd3,
        S_PAUSE     = 3'd4,
        S_OVER      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        T_NONE  = 2'd0,
        T_LEFT  = 2'd1,
        T_RIGHT = 2'd2
    } turn_t;

    localparam int                 c_ext_w       = CNT_W + 8;
    localparam logic [c_ext_w-1:0] c_base_ext    = c_ext_w'(BASE_PERIOD);
    localparam logic [c_ext_w-1:0] c_min_ext     = c_ext_w'(MIN_PERIOD);
    localparam logic [c_ext_w-1:0] c_speed_ext   = c_ext_w'(SPEED_STEP);
    localparam logic [c_ext_w-1:0] c_three_ext   = c_ext_w'(3);
    localparam logic [CNT_W-1:0]   c_base_cnt    = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0]   c_cd_last     = CNT_W'(BASE_PERIOD - 1);
    localparam logic [CNT_W-1:0]   c_one_cnt     = CNT_W'(1);
    localparam logic [1:0]         c_count_steps = 2'(COUNT_STEPS);

    state_t             r_state, w_state_nxt;
    turn_t              r_pending, w_pending_nxt, w_turn_req;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic [CNT_W-1:0]   r_period, w_period_nxt;
    logic [1:0]         r_countdown, w_countdown_nxt;
    logic [4:0]         r_high_score;
    logic               r_hs_armed;
    logic               w_turn_valid;
    logic               w_step_due;
    logic [c_ext_w-1:0] w_len_ext, w_reduction, w_period_ext;
    logic [CNT_W-1:0]   w_period_new;
    logic               w_unused_period_hi;

    assign score      = (length < 5'd3) ? 5'd0 : (length - 5'd3);
    assign state      = r_state;
    assign countdown  = r_countdown;
    assign high_score = r_high_score;

    // Wide intermediates keep the subtraction from wrapping on long snakes.
    always_comb begin
        w_len_ext   = (length < 5'd3) ? c_three_ext : c_ext_w'(length);
        w_reduction = c_speed_ext * (w_len_ext - c_three_ext);
        if (w_reduction >= (c_base_ext - c_min_ext)) begin
            w_period_ext = c_min_ext;
        end else begin
            w_period_ext = c_base_ext - w_reduction;
        end
    end

    assign w_period_new       = w_period_ext[CNT_W-1:0];
    assign w_unused_period_hi = &{1'b0, w_period_ext[c_ext_w-1:CNT_W]};

    // Simultaneous left+right cancels out.
    assign w_turn_valid = left_pulse ^ right_pulse;
    assign w_turn_req   = left_pulse ? T_LEFT : T_RIGHT;
    assign w_step_due   = (r_count == (r_period - c_one_cnt));

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_period_nxt    = r_period;
        w_countdown_nxt = r_countdown;
        w_pending_nxt   = r_pending;
        start           = 1'b0;
        step_en         = 1'b0;
        turn_left       = 1'b0;
        turn_right      = 1'b0;

        case (r_state)
            S_IDLE: begin
                start = 1'b1;
                if (center_pulse) begin
                    w_state_nxt = S_INIT;
                end
            end

            S_INIT: begin
                start           = 1'b1;
                step_en         = 1'b1;
                w_state_nxt     = S_COUNTDOWN;
                w_count_nxt     = '0;
                w_countdown_nxt = c_count_steps;
                w_pending_nxt   = T_NONE;
            end

            S_COUNTDOWN: begin
                if (r_count == c_cd_last) begin
                    w_count_nxt     = '0;
                    w_countdown_nxt = r_countdown - 2'd1;
                    if (r_countdown == 2'd1) begin
                        w_state_nxt  = S_PLAY;
                        w_period_nxt = c_base_cnt;
                    end
                end else begin
                    w_count_nxt = r_count + c_one_cnt;
                end
            end

            S_PLAY: begin
                if (die) begin
                    w_state_nxt = S_OVER;
                end else begin
                    if (w_step_due) begin
                        step_en       = 1'b1;
                        turn_left     = (r_pending == T_LEFT);
                        turn_right    = (r_pending == T_RIGHT);
                        w_count_nxt   = '0;
                        w_period_nxt  = w_period_new;
                        w_pending_nxt = w_turn_valid ? w_turn_req : T_NONE;
                    end else begin
                        // Counter holds on the pause request so resume picks up at the same count.
                        w_count_nxt = center_pulse ? r_count : (r_count + c_one_cnt);
                        if ((r_pending == T_NONE) && w_turn_valid) begin
                            w_pending_nxt = w_turn_req;
                        end
                    end
                    if (center_pulse) begin
                        w_state_nxt = S_PAUSE;
                    end
                end
            end

            S_PAUSE: begin
                if (center_pulse) begin
                    w_state_nxt = S_PLAY;
                end
            end

            S_OVER: begin
                if (center_pulse) begin
                    w_state_nxt = S_INIT;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_period     <= c_base_cnt;
            r_countdown  <= '0;
            r_pending    <= T_NONE;
            r_high_score <= '0;
            r_hs_armed   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_period    <= w_period_nxt;
            r_countdown <= w_countdown_nxt;
            r_pending   <= w_pending_nxt;
            r_hs_armed  <= (w_state_nxt == S_OVER) && (r_state != S_OVER);
            if (r_hs_armed && (score > r_high_score)) begin
                r_high_score <= score;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_game_ctrl
// Brief    : Self-checking bench for snake_game_ctrl with randomized stimulus
//            and a behavioural timing/turn-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_game_ctrl;

    localparam int BASE   = 25;
    localparam int MINP   = 8;
    localparam int SPD    = 1;
    localparam int CSTEPS = 3;

    logic       CLOCK = 1'b0;
    logic       reset;
    logic       center_pulse, left_pulse, right_pulse, die;
    logic [4:0] length;
    logic       start, step_en, turn_left, turn_right;
    logic [2:0] state;
    logic [1:0] countdown;
    logic [4:0] score, high_score;

    int n_pass  = 0;
    int n_total = 0;
    int viol    = 0;
    logic prev_step = 1'b0;

    snake_game_ctrl #(
        .CNT_W      (24),
        .BASE_PERIOD(BASE),
        .MIN_PERIOD (MINP),
        .SPEED_STEP (SPD),
        .COUNT_STEPS(CSTEPS)
    ) dut (
        .CLOCK       (CLOCK),
        .reset       (reset),
        .center_pulse(center_pulse),
        .left_pulse  (left_pulse),
        .right_pulse (right_pulse),
        .die         (die),
        .length      (length),
        .start       (start),
        .step_en     (step_en),
        .turn_left   (turn_left),
        .turn_right  (turn_right),
        .state       (state),
        .countdown   (countdown),
        .score       (score),
        .high_score  (high_score)
    );

    always #5 CLOCK = ~CLOCK;

    // Output invariants sampled mid-cycle.
    always @(negedge CLOCK) begin
        if (reset) begin
            prev_step <= 1'b0;
        end else begin
            if ((step_en && prev_step) || ((turn_left || turn_right) && !step_en) ||
                (turn_left && turn_right)) begin
                viol <= viol + 1;
            end
            prev_step <= step_en;
        end
    end

    function automatic int exp_period(input int len);
        int l;
        l = (len < 3) ? 3 : len;
        if (SPD * (l - 3) >= BASE - MINP) return MINP;
        return BASE - SPD * (l - 3);
    endfunction

    // One clock cycle with the given one-cycle inputs; outputs are readable on return.
    task automatic cyc(input logic c, input logic l, input logic r, input logic d);
        @(posedge CLOCK);
        #1;
        center_pulse = c;
        left_pulse   = l;
        right_pulse  = r;
        die          = d;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Cycles until step_en is seen (-1 if the bound expires).
    task automatic wait_step(input int max_cyc, output int n);
        n = 0;
        do begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end while (!step_en && n < max_cyc);
        if (!step_en) n = -1;
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        repeat (3) @(posedge CLOCK);
        #1;
        n_total++;
        if ({state, start, step_en, turn_left, turn_right, countdown, high_score} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0})
            $display("FAIL reset_values: state=%0d start=%0d step=%0d cd=%0d hs=%0d expected 0 1 0 0 0",
                     state, start, step_en, countdown, high_score);
        else n_pass++;
        @(posedge CLOCK);
        #1 reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (state !== 3'd0 || start !== 1'b1 || step_en !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL idle_hold: bad cycles got %0d expected 0", bad);
        else n_pass++;
        n_total++;
        if (high_score !== 5'd0) $display("FAIL idle_high_score: got %0d expected 0", high_score);
        else n_pass++;
    endtask

    task automatic test_start();
        logic [2:0] es;
        logic [1:0] ecd;
        logic       estep;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if ({state, start, step_en} !== {3'd1, 1'b1, 1'b1})
            $display("FAIL init_cycle: state=%0d start=%0d step=%0d expected 1 1 1", state, start, step_en);
        else n_pass++;
        // INIT is cycle 0; countdown runs cycles 1..75, first PLAY step on cycle 100 (the 101st).
        for (int k = 1; k <= CSTEPS * BASE + BASE; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            es    = (k <= CSTEPS * BASE) ? 3'd2 : 3'd3;
            ecd   = (k <= CSTEPS * BASE) ? 2'(CSTEPS - (k - 1) / BASE) : 2'd0;
            estep = (k == CSTEPS * BASE + BASE);
            n_total++;
            if ({state, countdown, start, step_en} !== {es, ecd, 1'b0, estep})
                $display("FAIL start_seq k=%0d: state=%0d cd=%0d start=%0d step=%0d expected %0d %0d 0 %0d",
                         k, state, countdown, start, step_en, es, ecd, estep);
            else n_pass++;
        end
    endtask

    task automatic test_turns();
        int n, a, b, used;
        bit dir;
        dir = bit'($urandom_range(0, 1));
        idle(BASE - 6);
        cyc(1'b0, !dir, dir, 1'b0);
        wait_step(40, n);
        n_total++;
        if (n !== 5 || {turn_left, turn_right} !== (dir ? 2'b01 : 2'b10))
            $display("FAIL turn_single: n=%0d tl=%0d tr=%0d expected 5 dir=%0d", n, turn_left, turn_right, dir);
        else n_pass++;
        wait_step(40, n);
        n_total++;
        if (n !== BASE || {turn_left, turn_right} !== 2'b00)
            $display("FAIL turn_once: n=%0d tl=%0d tr=%0d expected %0d 0 0", n, turn_left, turn_right, BASE);
        else n_pass++;

        a = $urandom_range(1, 10);
        b = $urandom_range(1, 5);
        dir = bit'($urandom_range(0, 1));
        idle(a);
        cyc(1'b0, !dir, dir, 1'b0);
        idle(b);
        cyc(1'b0, dir, !dir, 1'b0);
        used = a + b + 2;
        wait_step(40, n);
        n_total++;
        if (n !== BASE - used || {turn_left, turn_right} !== (dir ? 2'b01 : 2'b10))
            $display("FAIL turn_first_wins: n=%0d tl=%0d tr=%0d expected %0d dir=%0d", n, turn_left, turn_right, BASE - used, dir);
        else n_pass++;

        a = $urandom_range(1, 20);
        idle(a);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        wait_step(40, n);
        n_total++;
        if (n !== BASE - a - 1 || {turn_left, turn_right} !== 2'b00)
            $display("FAIL turn_both_dropped: n=%0d tl=%0d tr=%0d expected %0d 0 0", n, turn_left, turn_right, BASE - a - 1);
        else n_pass++;

        dir = bit'($urandom_range(0, 1));
        idle(BASE - 1);
        cyc(1'b0, !dir, dir, 1'b0);
        n_total++;
        if (step_en !== 1'b1 || {turn_left, turn_right} !== 2'b00)
            $display("FAIL turn_on_step_now: step=%0d tl=%0d tr=%0d expected 1 0 0", step_en, turn_left, turn_right);
        else n_pass++;
        wait_step(40, n);
        n_total++;
        if (n !== BASE || {turn_left, turn_right} !== (dir ? 2'b01 : 2'b10))
            $display("FAIL turn_on_step_next: n=%0d tl=%0d tr=%0d expected %0d dir=%0d", n, turn_left, turn_right, BASE, dir);
        else n_pass++;
    endtask

    task automatic test_speed();
        int lens[8];
        int n;
        lens = '{10, 31, 2, 0, 0, 0, 0, 0};
        for (int i = 3; i < 8; i++) lens[i] = $urandom_range(0, 31);
        foreach (lens[i]) begin
            length = 5'(lens[i]);
            wait_step(40, n);
            n_total++;
            if (n !== exp_period(lens[i]))
                $display("FAIL speed len=%0d: interval %0d expected %0d", lens[i], n, exp_period(lens[i]));
            else n_pass++;
        end
        length = 5'd3;
    endtask

    task automatic test_random();
        int  since, per;
        int  q[$];
        bit  l, r, es, etl, etr;
        since = 0;
        per   = exp_period(int'(length));
        for (int i = 0; i < 600; i++) begin
            l = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 7) == 0);
            cyc(1'b0, l, r, 1'b0);
            if ($urandom_range(0, 29) == 0) length = 5'($urandom_range(0, 31));
            since++;
            es  = (since == per);
            etl = es && (q.size() != 0) && (q[0] == 1);
            etr = es && (q.size() != 0) && (q[0] == 2);
            n_total++;
            if ({step_en, turn_left, turn_right} !== {es, etl, etr})
                $display("FAIL random i=%0d: step=%0d tl=%0d tr=%0d expected %0d %0d %0d",
                         i, step_en, turn_left, turn_right, es, etl, etr);
            else n_pass++;
            if (es) begin
                q.delete();
                since = 0;
                per   = exp_period(int'(length));
            end
            if ((l ^ r) && q.size() == 0) q.push_back(l ? 1 : 2);
        end
    endtask

    task automatic test_pause();
        int n, bad;
        length = 5'd3;
        wait_step(40, n);
        idle(10);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1'b0, ($urandom_range(0, 9) == 0), 1'b0, 1'b0);
            if (state !== 3'd4 || step_en !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL pause_hold: bad cycles got %0d expected 0", bad);
        else n_pass++;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        wait_step(40, n);
        n_total++;
        if (n !== BASE - 10 || {turn_left, turn_right} !== 2'b00)
            $display("FAIL pause_resume: n=%0d tl=%0d tr=%0d expected %0d 0 0", n, turn_left, turn_right, BASE - 10);
        else n_pass++;
    endtask

    task automatic test_death();
        int n, bad;
        length = 5'd7;
        idle(3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (state !== 3'd5 || high_score !== 5'd0)
            $display("FAIL death_enter: state=%0d hs=%0d expected 5 0", state, high_score);
        else n_pass++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (high_score !== 5'd4 || score !== 5'd4)
            $display("FAIL death_high_score: hs=%0d score=%0d expected 4 4", high_score, score);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (state !== 3'd5 || step_en !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL death_no_step: bad cycles got %0d expected 0", bad);
        else n_pass++;

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        wait_step(200, n);
        n_total++;
        if (n !== CSTEPS * BASE + BASE)
            $display("FAIL restart_first_step: n=%0d expected %0d", n, CSTEPS * BASE + BASE);
        else n_pass++;
        length = 5'd5;
        idle(exp_period(5) - 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        n_total++;
        if (step_en !== 1'b0) $display("FAIL die_blocks_step: step=%0d expected 0", step_en);
        else n_pass++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (state !== 3'd5) $display("FAIL die_beats_center: state=%0d expected 5", state);
        else n_pass++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (high_score !== 5'd4) $display("FAIL high_score_kept: hs=%0d expected 4", high_score);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n, bad;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        wait_step(200, n);
        length = 5'd20;
        idle(7);
        @(posedge CLOCK);
        #3 reset = 1'b1;
        #1;
        n_total++;
        if ({state, start, step_en, countdown, high_score} !== {3'd0, 1'b1, 1'b0, 2'd0, 5'd0})
            $display("FAIL reset_mid: state=%0d start=%0d step=%0d cd=%0d hs=%0d expected 0 1 0 0 0",
                     state, start, step_en, countdown, high_score);
        else n_pass++;
        repeat (2) @(posedge CLOCK);
        #1 reset = 1'b0;
        length = 5'd3;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (state !== 3'd0 || step_en !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL reset_mid_idle: bad cycles got %0d expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_invariants();
        n_total++;
        if (viol != 0) $display("FAIL invariants: violations got %0d expected 0", viol);
        else n_pass++;
    endtask

    initial begin
        reset        = 1'b1;
        center_pulse = 1'b0;
        left_pulse   = 1'b0;
        right_pulse  = 1'b0;
        die          = 1'b0;
        length       = 5'd3;
        test_reset();
        test_start();
        test_turns();
        test_speed();
        test_random();
        test_pause();
        test_death();
        test_reset_mid();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
